iq_tx_frame_sched: RTL and testbench



---
 rtl/iq_tx_pkg.sv | 8 +
 rtl/iq_tx_rr_arb2.sv | 15 +
 rtl/iq_tx_frame_sched.sv | 109 ++++++++++
 tb/tb_iq_tx_frame_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_tx_pkg.sv
// iq_tx_pkg: shared FSM state type, default preamble word and counter widths for the IQ tx frame scheduler
package iq_tx_pkg;
  typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, GAP} state_t;
  localparam logic [31:0] PREAMBLE_DEFAULT = 32'h5555_5555;
  localparam int PRE_W  = 4;
  localparam int GAP_W  = 8;
  localparam int BEAT_W = 16;
endpackage

// File: rtl/iq_tx_rr_arb2.sv
// iq_tx_rr_arb2: two-requester round-robin arbiter (req/en/upd in, one-hot gnt out; s0 wins the first tie after rst)
module iq_tx_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  output logic [1:0] gnt
);
  logic last1;
  always_comb gnt = !en ? 2'b00 : req == 2'b11 ? (last1 ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk)
    if (rst) last1 <= 1'b1;
    else if (upd) last1 <= gnt[1];
endmodule

// File: rtl/iq_tx_frame_sched.sv
// iq_tx_frame_sched: round-robin frame scheduler (s0/s1 AXIS in -> preamble, capped payload, idle gap on m AXIS; grant/busy/trunc/frame_cnt status)
module iq_tx_frame_sched
  import iq_tx_pkg::*;
#(
  parameter logic [31:0] PREAMBLE_WORD = PREAMBLE_DEFAULT,
  parameter int          PREAMBLE_LEN  = 2,
  parameter int          GAP_CYCLES    = 16,
  parameter int          MAX_WORDS     = 256
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic [31:0] s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  output logic        s0_tready,
  input  logic [31:0] s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  output logic        s1_tready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        trunc,
  output logic [15:0] frame_cnt
);
  state_t state, state_nx;
  logic [1:0] arb_gnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [BEAT_W-1:0] beat_cnt, beat_nx;
  logic [31:0] src_data;
  logic src_valid, src_last, at_max, pre_last, gap_done;
  iq_tx_rr_arb2 u_arb (
    .clk (clk100),
    .rst (reset),
    .req ({s1_tvalid, s0_tvalid}),
    .en  (state == IDLE),
    .upd (state == IDLE && |arb_gnt),
    .gnt (arb_gnt)
  );
  assign busy = state != IDLE;
  always_comb begin
    src_data = grant[1] ? s1_tdata : s0_tdata;
    src_valid = grant[1] ? s1_tvalid : s0_tvalid;
    src_last = grant[1] ? s1_tlast : s0_tlast;
    beat_nx = beat_cnt + 1'b1;
    at_max = beat_nx == BEAT_W'(MAX_WORDS);
    pre_last = pre_cnt == PRE_W'(PREAMBLE_LEN - 1);
    gap_done = GAP_CYCLES == 0 || gap_cnt == GAP_W'(GAP_CYCLES - 1);
  end
  always_comb begin
    state_nx = state;
    m_tdata = '0;
    m_tvalid = 1'b0;
    m_tlast = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state)
      IDLE: if (|arb_gnt) state_nx = PREAMBLE_LEN == 0 ? DATA : PRE;
      PRE: begin
        m_tdata = PREAMBLE_WORD;
        m_tvalid = 1'b1;
        if (m_tready && pre_last) state_nx = DATA;
      end
      DATA: begin
        m_tdata = src_data;
        m_tvalid = src_valid;
        m_tlast = src_valid && (src_last || at_max);
        s0_tready = grant[0] && m_tready;
        s1_tready = grant[1] && m_tready;
        if (src_valid && m_tready && (src_last || at_max)) state_nx = src_last ? GAP : DROP;
      end
      DROP: begin
        s0_tready = grant[0];
        s1_tready = grant[1];
        if (src_valid && src_last) state_nx = GAP;
      end
      GAP: if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk100)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      pre_cnt <= '0;
      gap_cnt <= '0;
      beat_cnt <= '0;
      trunc <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        grant <= arb_gnt;
        pre_cnt <= '0;
        gap_cnt <= '0;
        beat_cnt <= '0;
      end
      if (state == PRE && m_tready) pre_cnt <= pre_cnt + 1'b1;
      if (state == DATA && src_valid && m_tready) beat_cnt <= beat_nx;
      if (state == DATA && src_valid && m_tready && at_max && !src_last) trunc <= 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      if (state == GAP && gap_done) grant <= '0;
      if (state != GAP && state_nx == GAP) frame_cnt <= frame_cnt + 1'b1;
    end
endmodule

// File: tb/tb_iq_tx_frame_sched.sv
// tb_iq_tx_frame_sched: scoreboard bench driving three scheduler configurations (default, MAX_WORDS=4, no preamble/no gap)
module tb_iq_tx_frame_sched;
  logic clk100 = 1'b0;
  logic reset = 1'b1;
  logic [31:0] s0_tdata = '0, s1_tdata = '0;
  logic s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0, m_tready = 1'b1;
  logic [31:0] m_tdata [3];
  logic [2:0] m_tvalid, m_tlast, s0_tready, s1_tready, busy, trunc;
  logic [1:0] grant [3];
  logic [15:0] frame_cnt [3];
  int checks = 0, errors = 0, sel = 0, cyc = 0, hs_n = 0;
  logic mon_en = 1'b0, prev_v = 1'b0, tog = 1'b0;
  logic [32:0] exp_q [$];
  logic [32:0] got, want;
  int tl_q [$], rise_q [$], start_q [$];
  logic [1:0] gr_q [$];
  logic [31:0] pay [8][8];
  localparam logic [31:0] PW = 32'h5555_5555;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    iq_tx_frame_sched #(
      .PREAMBLE_LEN (g == 2 ? 0 : 2),
      .GAP_CYCLES   (g == 2 ? 0 : 16),
      .MAX_WORDS    (g == 1 ? 4 : 256)
    ) u_dut (
      .clk100    (clk100),
      .reset     (reset),
      .s0_tdata  (s0_tdata),
      .s0_tvalid (s0_tvalid),
      .s0_tlast  (s0_tlast),
      .s0_tready (s0_tready[g]),
      .s1_tdata  (s1_tdata),
      .s1_tvalid (s1_tvalid),
      .s1_tlast  (s1_tlast),
      .s1_tready (s1_tready[g]),
      .m_tdata   (m_tdata[g]),
      .m_tvalid  (m_tvalid[g]),
      .m_tlast   (m_tlast[g]),
      .m_tready  (m_tready),
      .grant     (grant[g]),
      .busy      (busy[g]),
      .trunc     (trunc[g]),
      .frame_cnt (frame_cnt[g])
    );
  end

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  always @(negedge clk100) if (mon_en) begin
    if (m_tvalid[sel] && !prev_v) begin
      rise_q.push_back(cyc);
      gr_q.push_back(grant[sel]);
    end
    prev_v = m_tvalid[sel];
    if (m_tvalid[sel] && m_tready) begin
      hs_n++;
      checks++;
      got = {m_tlast[sel], m_tdata[sel]};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_extra dut=%0d got last=%0b data=%h want no beat", sel, got[32], got[31:0]);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL beat dut=%0d got last=%0b data=%h want last=%0b data=%h", sel, got[32], got[31:0], want[32], want[31:0]);
        end
      end
      if (m_tlast[sel]) tl_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic int gap_idle(input int g);
    return (g == 0 ? 1 : g) + 1;
  endfunction

  task automatic expect_beat(input logic l, input logic [31:0] d);
    exp_q.push_back({l, d});
  endtask

  task automatic expect_pre(input int n);
    for (int i = 0; i < n; i++) expect_beat(1'b0, PW);
  endtask

  task automatic do_reset(input int s);
    mon_en = 1'b0;
    @(posedge clk100) #1;
    reset = 1'b1;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    s0_tlast = 1'b0;
    s1_tlast = 1'b0;
    m_tready = 1'b1;
    @(posedge clk100) #1;
    sel = s;
    exp_q.delete();
    tl_q.delete();
    rise_q.delete();
    start_q.delete();
    gr_q.delete();
    hs_n = 0;
    prev_v = 1'b0;
    mon_en = 1'b1;
    @(posedge clk100) #1;
    reset = 1'b0;
  endtask

  task automatic send(input int src, input int n, input int id);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      @(posedge clk100) #1;
      if (i == 0) start_q.push_back(cyc);
      if (src == 0) begin
        s0_tvalid = 1'b1;
        s0_tdata = pay[id][i];
        s0_tlast = i == n - 1;
      end else begin
        s1_tvalid = 1'b1;
        s1_tdata = pay[id][i];
        s1_tlast = i == n - 1;
      end
      do begin
        @(negedge clk100);
        t++;
      end while (!(src == 0 ? s0_tready[sel] : s1_tready[sel]) && t < 400);
      if (t >= 400) begin
        checks++;
        errors++;
        $display("FAIL send_timeout src=%0d beat=%0d got no tready want tready", src, i);
      end
    end
    @(posedge clk100) #1;
    if (src == 0) begin
      s0_tvalid = 1'b0;
      s0_tlast = 1'b0;
    end else begin
      s1_tvalid = 1'b0;
      s1_tlast = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk100);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d beats pending want 0", name, exp_q.size());
    end
    @(posedge clk100) #1;
  endtask

  task automatic test_reset;
    do_reset(0);
    @(negedge clk100);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({m_tvalid[k], m_tlast[k], m_tdata[k], s0_tready[k], s1_tready[k], grant[k], busy[k], trunc[k], frame_cnt[k]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut=%0d got v=%b l=%b d=%h r0=%b r1=%b g=%b busy=%b tr=%b fc=%0d want all 0",
                 k, m_tvalid[k], m_tlast[k], m_tdata[k], s0_tready[k], s1_tready[k], grant[k], busy[k], trunc[k], frame_cnt[k]);
      end
    end
  endtask

  task automatic test_single;
    do_reset(0);
    pay[0][0] = 32'h5555_5555;
    pay[0][1] = 32'h0000_FFFF;
    pay[0][2] = 32'hFFFF_0000;
    pay[1][0] = 32'hA5A5_0001;
    expect_pre(2);
    expect_beat(1'b0, 32'h5555_5555);
    expect_beat(1'b0, 32'h0000_FFFF);
    expect_beat(1'b1, 32'hFFFF_0000);
    expect_pre(2);
    expect_beat(1'b1, 32'hA5A5_0001);
    send(0, 3, 0);
    checks++;
    if (frame_cnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL single_frame_cnt got %0d want 1", frame_cnt[0]);
    end
    send(0, 1, 1);
    wait_drain("single");
    checks++;
    if (rise_q.size() != 2 || rise_q[0] !== start_q[0] + 1) begin
      errors++;
      $display("FAIL single_arb_latency got rise=%0d want %0d", rise_q.size() > 0 ? rise_q[0] : -1, start_q[0] + 1);
    end
    checks++;
    if (rise_q.size() != 2 || tl_q.size() != 2 || rise_q[1] - tl_q[0] - 1 !== gap_idle(16)) begin
      errors++;
      $display("FAIL single_gap got %0d idle cycles want %0d", rise_q.size() > 1 ? rise_q[1] - tl_q[0] - 1 : -1, gap_idle(16));
    end
    checks++;
    if (frame_cnt[0] !== 16'd2 || trunc[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_status got fc=%0d trunc=%b want fc=2 trunc=0", frame_cnt[0], trunc[0]);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [3];
    exp_g = '{2'b01, 2'b10, 2'b01};
    do_reset(0);
    for (int i = 0; i < 2; i++) begin
      pay[0][i] = 32'hA000_0000 + i;
      pay[1][i] = 32'hB000_0000 + i;
      pay[2][i] = 32'hC000_0000 + i;
    end
    for (int f = 0; f < 3; f++) begin
      expect_pre(2);
      expect_beat(1'b0, pay[f == 1 ? 1 : f == 2 ? 2 : 0][0]);
      expect_beat(1'b1, pay[f == 1 ? 1 : f == 2 ? 2 : 0][1]);
    end
    fork
      begin
        send(0, 2, 0);
        send(0, 2, 2);
      end
      send(1, 2, 1);
    join
    wait_drain("rr");
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (gr_q.size() != 3 || gr_q[f] !== exp_g[f]) begin
        errors++;
        $display("FAIL rr_grant frame=%0d got %b want %b", f, gr_q.size() > f ? gr_q[f] : 2'bxx, exp_g[f]);
      end
    end
    checks++;
    if (frame_cnt[0] !== 16'd3) begin
      errors++;
      $display("FAIL rr_frame_cnt got %0d want 3", frame_cnt[0]);
    end
  endtask

  task automatic test_backpressure;
    do_reset(0);
    for (int i = 0; i < 7; i++) pay[1][i] = 32'hC0DE_0000 + i * 32'h111;
    expect_pre(2);
    for (int i = 0; i < 7; i++) expect_beat(i == 6, pay[1][i]);
    tog = 1'b1;
    fork
      begin
        send(1, 7, 1);
        tog = 1'b0;
      end
      while (tog) begin
        @(posedge clk100) #1;
        m_tready = ~m_tready;
      end
    join
    m_tready = 1'b1;
    wait_drain("bp");
    checks++;
    if (hs_n !== 9 || tl_q.size() != 1) begin
      errors++;
      $display("FAIL bp_beats got %0d beats %0d lasts want 9 beats 1 last", hs_n, tl_q.size());
    end
  endtask

  task automatic test_truncate;
    do_reset(1);
    for (int i = 0; i < 6; i++) pay[3][i] = 32'hD000_0000 + i;
    expect_pre(2);
    for (int i = 0; i < 4; i++) expect_beat(i == 3, pay[3][i]);
    send(0, 6, 3);
    wait_drain("trunc");
    checks++;
    if (trunc[1] !== 1'b1 || frame_cnt[1] !== 16'd1 || tl_q.size() != 1) begin
      errors++;
      $display("FAIL trunc_status got trunc=%b fc=%0d lasts=%0d want trunc=1 fc=1 lasts=1", trunc[1], frame_cnt[1], tl_q.size());
    end
  endtask

  task automatic test_reset_mid;
    do_reset(0);
    pay[4][0] = 32'hE000_0001;
    pay[4][1] = 32'hE000_0002;
    pay[5][0] = 32'hF000_0001;
    pay[5][1] = 32'hF000_0002;
    expect_pre(2);
    expect_beat(1'b0, pay[4][0]);
    expect_beat(1'b0, pay[4][1]);
    for (int i = 0; i < 2; i++) begin
      int t;
      t = 0;
      @(posedge clk100) #1;
      s0_tvalid = 1'b1;
      s0_tdata = pay[4][i];
      s0_tlast = 1'b0;
      do begin
        @(negedge clk100);
        t++;
      end while (!s0_tready[0] && t < 100);
    end
    @(posedge clk100) #1;
    reset = 1'b1;
    s0_tvalid = 1'b0;
    @(posedge clk100) #1;
    reset = 1'b0;
    @(negedge clk100);
    checks++;
    if ({m_tvalid[0], m_tlast[0], m_tdata[0], s0_tready[0], s1_tready[0], grant[0], busy[0], trunc[0], frame_cnt[0]} !== '0) begin
      errors++;
      $display("FAIL midreset_state got v=%b l=%b d=%h g=%b busy=%b fc=%0d want all 0",
               m_tvalid[0], m_tlast[0], m_tdata[0], grant[0], busy[0], frame_cnt[0]);
    end
    checks++;
    if (exp_q.size() != 0 || tl_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_partial got pending=%0d lasts=%0d want 0 0", exp_q.size(), tl_q.size());
    end
    expect_pre(2);
    expect_beat(1'b0, pay[5][0]);
    expect_beat(1'b1, pay[5][1]);
    send(1, 2, 5);
    wait_drain("midreset");
    checks++;
    if (gr_q.size() != 2 || gr_q[1] !== 2'b10) begin
      errors++;
      $display("FAIL midreset_grant got %b want 10", gr_q.size() > 1 ? gr_q[1] : 2'bxx);
    end
  endtask

  task automatic test_zero_pre_gap;
    do_reset(2);
    pay[6][0] = 32'h1234_0000;
    pay[6][1] = 32'h1234_0001;
    pay[7][0] = 32'h5678_0000;
    pay[7][1] = 32'h5678_0001;
    expect_beat(1'b0, pay[6][0]);
    expect_beat(1'b1, pay[6][1]);
    expect_beat(1'b0, pay[7][0]);
    expect_beat(1'b1, pay[7][1]);
    send(0, 2, 6);
    send(0, 2, 7);
    wait_drain("zero");
    checks++;
    if (rise_q.size() != 2 || rise_q[0] !== start_q[0] + 1) begin
      errors++;
      $display("FAIL zero_latency got rise=%0d want %0d", rise_q.size() > 0 ? rise_q[0] : -1, start_q[0] + 1);
    end
    checks++;
    if (rise_q.size() != 2 || tl_q.size() != 2 || rise_q[1] - tl_q[0] - 1 !== gap_idle(0)) begin
      errors++;
      $display("FAIL zero_gap got %0d idle cycles want %0d", rise_q.size() > 1 ? rise_q[1] - tl_q[0] - 1 : -1, gap_idle(0));
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_truncate;
    test_reset_mid;
    test_zero_pre_gap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
